// File: rtl/battle_sequencer_pkg.sv
// Shared encodings for the battle game sequencer: state codes, winner codes,
// choice one-hots, key indices and the per-state datapath command decode.
package battle_sequencer_pkg;

  typedef enum logic [4:0] {
    ST_TITLE          = 5'd0,
    ST_WAIT_START     = 5'd1,
    ST_SEL1_BG        = 5'd2,
    ST_P1_CHOOSE      = 5'd3,
    ST_P1_CHOOSE_DRAW = 5'd4,
    ST_SEL2_BG        = 5'd5,
    ST_P2_CHOOSE      = 5'd6,
    ST_P2_CHOOSE_DRAW = 5'd7,
    ST_BATTLE_BG      = 5'd8,
    ST_DRAW_P1        = 5'd9,
    ST_DRAW_P2        = 5'd10,
    ST_P1_MENU        = 5'd11,
    ST_P1_WAIT        = 5'd12,
    ST_P1_ANIM        = 5'd13,
    ST_P1_CHECK       = 5'd14,
    ST_P2_MENU        = 5'd15,
    ST_P2_WAIT        = 5'd16,
    ST_P2_ANIM        = 5'd17,
    ST_P2_CHECK       = 5'd18,
    ST_WIN            = 5'd19,
    ST_GAME_OVER      = 5'd20
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic [2:0] CH_NONE   = 3'b000;
  localparam logic [2:0] CH_BULB   = 3'b001;
  localparam logic [2:0] CH_CHAR   = 3'b010;
  localparam logic [2:0] CH_SQUIRT = 3'b100;

  localparam int NUM_KEYS  = 6;
  localparam int K_START   = 0;
  localparam int K_BULB    = 1;
  localparam int K_CHAR    = 2;
  localparam int K_SQUIRT  = 3;
  localparam int K_ATTACK  = 4;
  localparam int K_SPECIAL = 5;

  typedef struct packed {
    logic start_game;
    logic load_p1_bg;
    logic load_p2_bg;
    logic p1_select;
    logic p2_select;
    logic battle_bg;
    logic draw_p1;
    logic draw_p2;
    logic p1_menu;
    logic p2_menu;
  } cmd_t;

  function automatic cmd_t cmd_of(state_e s);
    cmd_t c;
    c = '0;
    case (s)
      ST_TITLE:                        c.start_game = 1'b1;
      ST_SEL1_BG:                      c.load_p1_bg = 1'b1;
      ST_P1_CHOOSE, ST_P1_CHOOSE_DRAW: c.p1_select  = 1'b1;
      ST_SEL2_BG:                      c.load_p2_bg = 1'b1;
      ST_P2_CHOOSE, ST_P2_CHOOSE_DRAW: c.p2_select  = 1'b1;
      ST_BATTLE_BG:                    c.battle_bg  = 1'b1;
      ST_DRAW_P1:                      c.draw_p1    = 1'b1;
      ST_DRAW_P2:                      c.draw_p2    = 1'b1;
      ST_P1_MENU:                      c.p1_menu    = 1'b1;
      ST_P2_MENU:                      c.p2_menu    = 1'b1;
      default:                         c = '0;
    endcase
    return c;
  endfunction

  // States that wait on draw_done and are covered by the watchdog.
  function automatic logic is_draw(state_e s);
    case (s)
      ST_TITLE, ST_SEL1_BG, ST_P1_CHOOSE_DRAW, ST_SEL2_BG, ST_P2_CHOOSE_DRAW,
      ST_BATTLE_BG, ST_DRAW_P1, ST_DRAW_P2, ST_P1_MENU, ST_P1_ANIM,
      ST_P2_MENU, ST_P2_ANIM, ST_WIN: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] pick_choice(logic bulb, logic chr, logic squirt);
    if (bulb)        return CH_BULB;
    else if (chr)    return CH_CHAR;
    else if (squirt) return CH_SQUIRT;
    else             return CH_NONE;
  endfunction

endpackage

// File: rtl/battle_sequencer_if.sv
// Key, datapath-handshake and command bundle between the sequencer (master)
// and the datapath/input side (slave).
interface battle_sequencer_if;
  logic start_key, key_bulb, key_char, key_squirt, key_attack, key_special;
  logic draw_done, p1_dead, p2_dead;
  logic start_game, load_poke1_select_background, load_poke2_select_background;
  logic player_1_select, player_2_select, battle_background;
  logic draw_player_1_pokemon, draw_player_2_pokemon;
  logic p1_attacks, p2_attacks;
  logic p1_attack_1, p1_special_attack, p2_attack_1, p2_special_attack;
  logic p1_bulbasaur, p1_charmander, p1_squirtle;
  logic p2_bulbasaur, p2_charmander, p2_squirtle;
  logic [1:0] winner;
  logic timeout_err;
  logic [4:0] state_dbg;

  modport master (
    input  start_key, key_bulb, key_char, key_squirt, key_attack, key_special,
    input  draw_done, p1_dead, p2_dead,
    output start_game, load_poke1_select_background, load_poke2_select_background,
    output player_1_select, player_2_select, battle_background,
    output draw_player_1_pokemon, draw_player_2_pokemon, p1_attacks, p2_attacks,
    output p1_attack_1, p1_special_attack, p2_attack_1, p2_special_attack,
    output p1_bulbasaur, p1_charmander, p1_squirtle,
    output p2_bulbasaur, p2_charmander, p2_squirtle,
    output winner, timeout_err, state_dbg
  );

  modport slave (
    output start_key, key_bulb, key_char, key_squirt, key_attack, key_special,
    output draw_done, p1_dead, p2_dead,
    input  start_game, load_poke1_select_background, load_poke2_select_background,
    input  player_1_select, player_2_select, battle_background,
    input  draw_player_1_pokemon, draw_player_2_pokemon, p1_attacks, p2_attacks,
    input  p1_attack_1, p1_special_attack, p2_attack_1, p2_special_attack,
    input  p1_bulbasaur, p1_charmander, p1_squirtle,
    input  p2_bulbasaur, p2_charmander, p2_squirtle,
    input  winner, timeout_err, state_dbg
  );
endinterface

// File: rtl/battle_sequencer_edge_pulse.sv
// Multi-bit rising-edge detector: one-cycle pulse per 0->1 transition of each bit.
module edge_pulse #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] din,
  output logic [W-1:0] pulse
);

  logic [W-1:0] prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) prev <= '0;
    else         prev <= din;
  end

  assign pulse = din & ~prev;

endmodule

// File: rtl/battle_sequencer.sv
// Top-level game control FSM: sequences datapath draws one at a time, gates key
// presses, tracks turns, special-attack cooldowns and the winner.
module battle_sequencer #(
  parameter int DONE_TIMEOUT     = 20000,
  parameter int SPECIAL_COOLDOWN = 2,
  parameter int CD_W             = 2
) (
  input logic                clock,
  input logic                resetn,
  battle_sequencer_if.master bus
);
  import battle_sequencer_pkg::*;

  localparam int WD_W = $clog2(DONE_TIMEOUT + 1);

  logic [NUM_KEYS-1:0] keys, press;
  state_e              state, nxt;
  cmd_t                cmd;
  logic                armed, terr;
  logic [WD_W-1:0]     wd;
  logic [CD_W-1:0]     cd1, cd2;
  logic [2:0]          ch1, ch2;
  logic [1:0]          win;
  logic                a1, s1, a2, s2;
  logic                in_draw, wd_expire, draw_adv, sp1_ok, sp2_ok;

  assign keys = {bus.key_special, bus.key_attack, bus.key_squirt,
                 bus.key_char, bus.key_bulb, bus.start_key};

  edge_pulse #(.W(NUM_KEYS)) u_keys (
    .clock (clock),
    .resetn(resetn),
    .din   (keys),
    .pulse (press)
  );

  // armed holds off the first TITLE draw until its command has actually been raised.
  always_comb begin
    in_draw   = is_draw(state);
    wd_expire = (wd == WD_W'(DONE_TIMEOUT - 1));
    draw_adv  = armed & in_draw & (bus.draw_done | wd_expire);
    sp1_ok    = press[K_SPECIAL] & ~press[K_ATTACK] & (cd1 == '0);
    sp2_ok    = press[K_SPECIAL] & ~press[K_ATTACK] & (cd2 == '0);
    nxt       = state;
    case (state)
      ST_TITLE:          if (draw_adv) nxt = ST_WAIT_START;
      ST_WAIT_START:     if (press[K_START]) nxt = ST_SEL1_BG;
      ST_SEL1_BG:        if (draw_adv) nxt = ST_P1_CHOOSE;
      ST_P1_CHOOSE:      if (|press[K_SQUIRT:K_BULB]) nxt = ST_P1_CHOOSE_DRAW;
      ST_P1_CHOOSE_DRAW: if (draw_adv) nxt = ST_SEL2_BG;
      ST_SEL2_BG:        if (draw_adv) nxt = ST_P2_CHOOSE;
      ST_P2_CHOOSE:      if (|press[K_SQUIRT:K_BULB]) nxt = ST_P2_CHOOSE_DRAW;
      ST_P2_CHOOSE_DRAW: if (draw_adv) nxt = ST_BATTLE_BG;
      ST_BATTLE_BG:      if (draw_adv) nxt = ST_DRAW_P1;
      ST_DRAW_P1:        if (draw_adv) nxt = ST_DRAW_P2;
      ST_DRAW_P2:        if (draw_adv) nxt = ST_P1_MENU;
      ST_P1_MENU:        if (draw_adv) nxt = ST_P1_WAIT;
      ST_P1_WAIT:        if (press[K_ATTACK] | sp1_ok) nxt = ST_P1_ANIM;
      ST_P1_ANIM:        if (draw_adv) nxt = ST_P1_CHECK;
      ST_P1_CHECK:       nxt = bus.p2_dead ? ST_WIN : ST_P2_MENU;
      ST_P2_MENU:        if (draw_adv) nxt = ST_P2_WAIT;
      ST_P2_WAIT:        if (press[K_ATTACK] | sp2_ok) nxt = ST_P2_ANIM;
      ST_P2_ANIM:        if (draw_adv) nxt = ST_P2_CHECK;
      ST_P2_CHECK:       nxt = bus.p1_dead ? ST_WIN : ST_P1_MENU;
      ST_WIN:            if (draw_adv) nxt = ST_GAME_OVER;
      ST_GAME_OVER:      if (press[K_START]) nxt = ST_TITLE;
      default:           nxt = ST_TITLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_TITLE;
      cmd   <= '0;
      armed <= 1'b0;
      terr  <= 1'b0;
      wd    <= '0;
      cd1   <= '0;
      cd2   <= '0;
      ch1   <= CH_NONE;
      ch2   <= CH_NONE;
      win   <= WIN_NONE;
      a1    <= 1'b0;
      s1    <= 1'b0;
      a2    <= 1'b0;
      s2    <= 1'b0;
    end else begin
      state <= nxt;
      cmd   <= cmd_of(nxt);
      armed <= 1'b1;
      wd    <= (in_draw && armed && nxt == state) ? wd + WD_W'(1) : '0;
      if (in_draw && armed && !bus.draw_done && wd_expire) terr <= 1'b1;

      a1 <= (state == ST_P1_WAIT) && press[K_ATTACK];
      s1 <= (state == ST_P1_WAIT) && sp1_ok;
      a2 <= (state == ST_P2_WAIT) && press[K_ATTACK];
      s2 <= (state == ST_P2_WAIT) && sp2_ok;

      if (state == ST_P1_WAIT && sp1_ok) cd1 <= CD_W'(SPECIAL_COOLDOWN);
      else if (nxt == ST_P1_MENU && state != ST_P1_MENU && cd1 != '0) cd1 <= cd1 - CD_W'(1);
      if (state == ST_P2_WAIT && sp2_ok) cd2 <= CD_W'(SPECIAL_COOLDOWN);
      else if (nxt == ST_P2_MENU && state != ST_P2_MENU && cd2 != '0) cd2 <= cd2 - CD_W'(1);

      if (state == ST_P1_CHOOSE && nxt == ST_P1_CHOOSE_DRAW)
        ch1 <= pick_choice(press[K_BULB], press[K_CHAR], press[K_SQUIRT]);
      if (state == ST_P2_CHOOSE && nxt == ST_P2_CHOOSE_DRAW)
        ch2 <= pick_choice(press[K_BULB], press[K_CHAR], press[K_SQUIRT]);

      // Each check only looks at the opponent, so the attacker wins a double KO.
      if (state == ST_P1_CHECK && bus.p2_dead) win <= WIN_P1;
      if (state == ST_P2_CHECK && bus.p1_dead) win <= WIN_P2;

      if (state == ST_GAME_OVER && nxt == ST_TITLE) begin
        ch1 <= CH_NONE;
        ch2 <= CH_NONE;
        win <= WIN_NONE;
        cd1 <= '0;
        cd2 <= '0;
      end
    end
  end

  assign bus.start_game                   = cmd.start_game;
  assign bus.load_poke1_select_background = cmd.load_p1_bg;
  assign bus.load_poke2_select_background = cmd.load_p2_bg;
  assign bus.player_1_select              = cmd.p1_select;
  assign bus.player_2_select              = cmd.p2_select;
  assign bus.battle_background            = cmd.battle_bg;
  assign bus.draw_player_1_pokemon        = cmd.draw_p1;
  assign bus.draw_player_2_pokemon        = cmd.draw_p2;
  assign bus.p1_attacks                   = cmd.p1_menu;
  assign bus.p2_attacks                   = cmd.p2_menu;
  assign bus.p1_attack_1                  = a1;
  assign bus.p1_special_attack            = s1;
  assign bus.p2_attack_1                  = a2;
  assign bus.p2_special_attack            = s2;
  assign bus.p1_bulbasaur                 = ch1[0];
  assign bus.p1_charmander                = ch1[1];
  assign bus.p1_squirtle                  = ch1[2];
  assign bus.p2_bulbasaur                 = ch2[0];
  assign bus.p2_charmander                = ch2[1];
  assign bus.p2_squirtle                  = ch2[2];
  assign bus.winner                       = win;
  assign bus.timeout_err                  = terr;
  assign bus.state_dbg                    = state;

endmodule

// File: tb/tb_battle_sequencer.sv
// Directed bench for battle_sequencer: walks a full game with hand-computed
// expectations for selection, cooldown, watchdog, win and async reset.
module tb_battle_sequencer;
  import battle_sequencer_pkg::*;

  localparam logic [5:0] B_START = 6'b000001, B_BULB = 6'b000010, B_CHAR = 6'b000100,
                         B_SQUIRT = 6'b001000, B_ATTACK = 6'b010000, B_SPECIAL = 6'b100000;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  battle_sequencer_if bus();

  battle_sequencer #(.DONE_TIMEOUT(20000), .SPECIAL_COOLDOWN(2), .CD_W(2)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [5:0] k);
    bus.start_key   = k[0];
    bus.key_bulb    = k[1];
    bus.key_char    = k[2];
    bus.key_squirt  = k[3];
    bus.key_attack  = k[4];
    bus.key_special = k[5];
    tick();
    {bus.key_special, bus.key_attack, bus.key_squirt, bus.key_char, bus.key_bulb, bus.start_key} = '0;
  endtask

  task automatic wait_state(input logic [4:0] s, output int n);
    n = 0;
    while (bus.state_dbg !== s && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    logic [5:0] ch;
    resetn = 1'b0;
    repeat (2) tick();
    ch = {bus.p2_squirtle, bus.p2_charmander, bus.p2_bulbasaur, bus.p1_squirtle, bus.p1_charmander, bus.p1_bulbasaur};
    checks++; if (bus.state_dbg !== 5'(ST_TITLE)) begin failures++; $display("FAIL reset_state got=%0d want=%0d", bus.state_dbg, ST_TITLE); end
    checks++; if (bus.start_game !== 1'b0) begin failures++; $display("FAIL reset_start_game got=%b want=0", bus.start_game); end
    checks++; if (ch !== 6'b0) begin failures++; $display("FAIL reset_choices got=%b want=000000", ch); end
    checks++; if (bus.winner !== 2'b00 || bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_winner_terr got=%b/%b want=00/0", bus.winner, bus.timeout_err); end
    resetn = 1'b1;
    tick();
    checks++; if (bus.state_dbg !== 5'(ST_TITLE) || bus.start_game !== 1'b1) begin failures++; $display("FAIL title_draw got=%0d/%b want=%0d/1", bus.state_dbg, bus.start_game, ST_TITLE); end
    tick();
    checks++; if (bus.state_dbg !== 5'(ST_WAIT_START) || bus.start_game !== 1'b0) begin failures++; $display("FAIL to_wait_start got=%0d/%b want=%0d/0", bus.state_dbg, bus.start_game, ST_WAIT_START); end
  endtask

  task automatic test_select;
    int n;
    logic [2:0] v;
    press(B_START);
    checks++; if (bus.state_dbg !== 5'(ST_SEL1_BG) || bus.load_poke1_select_background !== 1'b1) begin failures++; $display("FAIL sel1_bg got=%0d/%b want=%0d/1", bus.state_dbg, bus.load_poke1_select_background, ST_SEL1_BG); end
    wait_state(ST_P1_CHOOSE, n);
    checks++; if (bus.state_dbg !== 5'(ST_P1_CHOOSE) || bus.player_1_select !== 1'b1) begin failures++; $display("FAIL p1_choose got=%0d/%b want=%0d/1", bus.state_dbg, bus.player_1_select, ST_P1_CHOOSE); end
    press(B_CHAR);
    v = {bus.p1_squirtle, bus.p1_charmander, bus.p1_bulbasaur};
    checks++; if (v !== 3'b010 || bus.player_1_select !== 1'b1) begin failures++; $display("FAIL p1_choice got=%b/%b want=010/1", v, bus.player_1_select); end
    wait_state(ST_P2_CHOOSE, n);
    checks++; if (bus.state_dbg !== 5'(ST_P2_CHOOSE)) begin failures++; $display("FAIL p2_choose_reach got=%0d want=%0d", bus.state_dbg, ST_P2_CHOOSE); end
    press(B_BULB | B_SQUIRT);
    v = {bus.p2_squirtle, bus.p2_charmander, bus.p2_bulbasaur};
    checks++; if (v !== 3'b001 || bus.player_2_select !== 1'b1) begin failures++; $display("FAIL p2_choice_priority got=%b/%b want=001/1", v, bus.player_2_select); end
  endtask

  task automatic test_timeout;
    int cnt;
    logic te_early;
    tick();
    bus.draw_done = 1'b0;
    checks++; if (bus.state_dbg !== 5'(ST_BATTLE_BG) || bus.battle_background !== 1'b1) begin failures++; $display("FAIL battle_bg got=%0d/%b want=%0d/1", bus.state_dbg, bus.battle_background, ST_BATTLE_BG); end
    cnt = 0;
    te_early = 1'bx;
    while (bus.state_dbg === 5'(ST_BATTLE_BG) && cnt < 25000) begin
      tick();
      cnt++;
      if (cnt == 19999) te_early = bus.timeout_err;
    end
    bus.draw_done = 1'b1;
    checks++; if (cnt != 20000) begin failures++; $display("FAIL watchdog_cycles got=%0d want=20000", cnt); end
    checks++; if (te_early !== 1'b0) begin failures++; $display("FAIL terr_early got=%b want=0", te_early); end
    checks++; if (bus.timeout_err !== 1'b1 || bus.state_dbg !== 5'(ST_DRAW_P1)) begin failures++; $display("FAIL terr_set got=%b/%0d want=1/%0d", bus.timeout_err, bus.state_dbg, ST_DRAW_P1); end
  endtask

  task automatic test_cooldown;
    int n;
    wait_state(ST_P1_MENU, n);
    checks++; if (bus.p1_attacks !== 1'b1) begin failures++; $display("FAIL p1_menu got=%b want=1", bus.p1_attacks); end
    wait_state(ST_P1_WAIT, n);
    press(B_SPECIAL);
    checks++; if (bus.p1_special_attack !== 1'b1 || bus.state_dbg !== 5'(ST_P1_ANIM)) begin failures++; $display("FAIL special_1 got=%b/%0d want=1/%0d", bus.p1_special_attack, bus.state_dbg, ST_P1_ANIM); end
    tick();
    checks++; if (bus.p1_special_attack !== 1'b0) begin failures++; $display("FAIL special_1_width got=%b want=0", bus.p1_special_attack); end
    wait_state(ST_P2_WAIT, n);
    press(B_ATTACK | B_SPECIAL);
    checks++; if (bus.p2_attack_1 !== 1'b1 || bus.p2_special_attack !== 1'b0) begin failures++; $display("FAIL p2_attack_priority got=%b/%b want=1/0", bus.p2_attack_1, bus.p2_special_attack); end
    wait_state(ST_P1_WAIT, n);
    press(B_SPECIAL);
    checks++; if (bus.p1_special_attack !== 1'b0 || bus.state_dbg !== 5'(ST_P1_WAIT)) begin failures++; $display("FAIL special_cooldown got=%b/%0d want=0/%0d", bus.p1_special_attack, bus.state_dbg, ST_P1_WAIT); end
    press(B_ATTACK);
    checks++; if (bus.p1_attack_1 !== 1'b1) begin failures++; $display("FAIL p1_attack got=%b want=1", bus.p1_attack_1); end
    tick();
    checks++; if (bus.p1_attack_1 !== 1'b0) begin failures++; $display("FAIL p1_attack_width got=%b want=0", bus.p1_attack_1); end
    wait_state(ST_P2_WAIT, n);
    press(B_ATTACK);
    wait_state(ST_P1_WAIT, n);
    press(B_SPECIAL);
    checks++; if (bus.p1_special_attack !== 1'b1) begin failures++; $display("FAIL special_again got=%b want=1", bus.p1_special_attack); end
  endtask

  task automatic test_win;
    int n;
    logic [5:0] ch;
    bus.p2_dead = 1'b1;
    tick();
    tick();
    bus.p2_dead = 1'b0;
    checks++; if (bus.state_dbg !== 5'(ST_WIN) || bus.winner !== 2'b01) begin failures++; $display("FAIL win_p1 got=%0d/%b want=%0d/01", bus.state_dbg, bus.winner, ST_WIN); end
    checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL terr_sticky got=%b want=1", bus.timeout_err); end
    wait_state(ST_GAME_OVER, n);
    press(B_START);
    ch = {bus.p2_squirtle, bus.p2_charmander, bus.p2_bulbasaur, bus.p1_squirtle, bus.p1_charmander, bus.p1_bulbasaur};
    checks++; if (bus.state_dbg !== 5'(ST_TITLE) || bus.winner !== 2'b00) begin failures++; $display("FAIL game_over_exit got=%0d/%b want=%0d/00", bus.state_dbg, bus.winner, ST_TITLE); end
    checks++; if (ch !== 6'b0 || bus.timeout_err !== 1'b1) begin failures++; $display("FAIL game_over_clear got=%b/%b want=000000/1", ch, bus.timeout_err); end
  endtask

  task automatic test_reset_mid_draw;
    int n;
    wait_state(ST_WAIT_START, n);
    press(B_START);
    wait_state(ST_P1_CHOOSE, n);
    press(B_BULB);
    wait_state(ST_P2_CHOOSE, n);
    press(B_CHAR);
    wait_state(ST_DRAW_P1, n);
    bus.draw_done = 1'b0;
    checks++; if (bus.draw_player_1_pokemon !== 1'b1 || bus.p1_bulbasaur !== 1'b1) begin failures++; $display("FAIL draw_p1_live got=%b/%b want=1/1", bus.draw_player_1_pokemon, bus.p1_bulbasaur); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (bus.state_dbg !== 5'(ST_TITLE) || bus.draw_player_1_pokemon !== 1'b0) begin failures++; $display("FAIL async_reset_state got=%0d/%b want=%0d/0", bus.state_dbg, bus.draw_player_1_pokemon, ST_TITLE); end
    checks++; if (bus.p1_bulbasaur !== 1'b0 || bus.p2_charmander !== 1'b0 || bus.start_game !== 1'b0 || bus.timeout_err !== 1'b0) begin failures++; $display("FAIL async_reset_outs got=%b%b%b%b want=0000", bus.p1_bulbasaur, bus.p2_charmander, bus.start_game, bus.timeout_err); end
    tick();
    bus.draw_done = 1'b1;
    resetn = 1'b1;
  endtask

  initial begin
    {bus.key_special, bus.key_attack, bus.key_squirt, bus.key_char, bus.key_bulb, bus.start_key} = '0;
    bus.draw_done = 1'b1;
    bus.p1_dead   = 1'b0;
    bus.p2_dead   = 1'b0;
    test_reset();
    test_select();
    test_timeout();
    test_cooldown();
    test_win();
    test_reset_mid_draw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
